// File: rtl/fetch_pkg_r32i.sv
// Shared definitions for the RV32I instruction fetch unit.
//   NopIns             : canonical NOP (addi x0,x0,0) shown to the decoder when idle
//   DefaultResetVector : PC after reset unless overridden by the top parameter
//   fetchEntryT        : one prefetch FIFO entry, {fetch address, instruction word}
package fetch_pkg_r32i;

    localparam logic [31:0] NopIns             = 32'h0000_0013;
    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetchEntryT;

endpackage

// File: rtl/fetch_fifo_r32i.sv
// Small synchronous FIFO used for both the prefetch buffer and the address-tag
// queue of the fetch unit. Storage is a register array; the head entry is read
// directly from it, so a word pushed in cycle N is at the head in cycle N+1.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   push, pushData     : write request and entry (dropped when full unless popping)
//   pop                : remove head entry (ignored when empty)
//   flush              : discard all entries; wins over push and pop
//   headData           : oldest entry (undefined contents when empty)
//   count, full, empty : occupancy status
module fetch_fifo_r32i #(
    parameter type EntryT = logic [31:0],
    parameter int  Depth  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  EntryT                  pushData,
    input  logic                   pop,
    input  logic                   flush,
    output EntryT                  headData,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PtrW = $clog2(Depth);

    EntryT            memArray [Depth];
    logic [PtrW-1:0]  wrPtrReg;
    logic [PtrW-1:0]  rdPtrReg;
    logic [PtrW:0]    countReg;
    logic             doPush;
    logic             doPop;

    assign full     = (countReg == (PtrW+1)'(Depth));
    assign empty    = (countReg == '0);
    assign count    = countReg;
    assign headData = memArray[rdPtrReg];

    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign doPop  = pop && !flush && !empty;
    assign doPush = push && !flush && (!full || doPop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + PtrW'(1);
            if (doPop)  rdPtrReg <= rdPtrReg + PtrW'(1);
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + (PtrW+1)'(1);
                2'b01:   countReg <= countReg - (PtrW+1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) memArray[wrPtrReg] <= pushData;
    end

endmodule

// File: rtl/instr_fetch_r32i.sv
// RV32I instruction fetch unit: owns the PC, issues word fetches over a
// valid/ready request channel (in-order responses), buffers returned words in
// a prefetch FIFO and hands them to the decoder with a valid/ready handshake.
// A redirect flushes buffered words and marks in-flight fetches as stale.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   MemReqValid/MemReqReady/MemReqAddr : fetch request channel
//   MemRespValid/MemRespData           : in-order fetch responses
//   InsValid/InsReady/rawIns/InsAddr   : instruction handed to the decoder
//   BranchTaken/BranchTarget           : redirect request
//   MisalignErr                        : one-cycle pulse for a misaligned target
module instr_fetch_r32i
    import fetch_pkg_r32i::*;
#(
    parameter int               dataW       = 32,
    parameter int               Depth       = 4,
    parameter logic [dataW-1:0] ResetVector = dataW'(DefaultResetVector)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             MemReqValid,
    input  logic             MemReqReady,
    output logic [dataW-1:0] MemReqAddr,
    input  logic             MemRespValid,
    input  logic [dataW-1:0] MemRespData,
    output logic             InsValid,
    input  logic             InsReady,
    output logic [dataW-1:0] rawIns,
    output logic [dataW-1:0] InsAddr,
    input  logic             BranchTaken,
    input  logic [dataW-1:0] BranchTarget,
    output logic             MisalignErr
);

    localparam int CntW  = $clog2(Depth) + 1;
    // Stale fetches can pile up across back-to-back redirects while memory is
    // slow, so the drop counter is wider than the outstanding counter.
    localparam int DropW = CntW + 4;

    logic [dataW-1:0] pcReg, pcNext;
    logic [CntW-1:0]  outstandingReg, outstandingNext;
    logic [DropW-1:0] dropReg, dropNext;
    logic             misalignReg;

    logic             reqAccept;
    logic             dropping;
    logic             respKeep;
    logic             creditOk;
    logic [CntW:0]    inFlight;

    fetchEntryT       fifoHead;
    logic [CntW-1:0]  fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [dataW-1:0] tagHead;
    logic [CntW-1:0]  tagCount;
    logic             tagFull;
    logic             tagEmpty;
    logic             unusedStatus;

    assign dropping  = (dropReg != '0);
    assign respKeep  = MemRespValid && !dropping;
    assign reqAccept = MemReqValid && MemReqReady;

    // Buffered plus outstanding words never exceed Depth, so every response
    // that is kept is guaranteed a FIFO slot.
    assign inFlight    = {1'b0, fifoCount} + {1'b0, outstandingReg};
    assign creditOk    = (inFlight < (CntW+1)'(Depth));
    assign MemReqValid = !reset && !BranchTaken && creditOk;
    assign MemReqAddr  = pcReg;

    // Addresses of live (non-stale) requests, consumed as their data returns.
    fetch_fifo_r32i #(
        .EntryT (logic [dataW-1:0]),
        .Depth  (Depth)
    ) tagQueue (
        .clk      (clk),
        .reset    (reset),
        .push     (reqAccept),
        .pushData (pcReg),
        .pop      (respKeep),
        .flush    (BranchTaken),
        .headData (tagHead),
        .count    (tagCount),
        .full     (tagFull),
        .empty    (tagEmpty)
    );

    fetch_fifo_r32i #(
        .EntryT (fetchEntryT),
        .Depth  (Depth)
    ) insFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (respKeep),
        .pushData ('{addr: tagHead, data: MemRespData}),
        .pop      (InsValid && InsReady),
        .flush    (BranchTaken),
        .headData (fifoHead),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Occupancy of the tag queue mirrors outstandingReg and the credit rule
    // keeps the prefetch FIFO from filling past capacity.
    assign unusedStatus = ^{fifoFull, tagCount, tagFull, tagEmpty};

    assign InsValid    = !fifoEmpty;
    assign rawIns      = InsValid ? fifoHead.data : NopIns;
    assign InsAddr     = InsValid ? fifoHead.addr : '0;
    assign MisalignErr = misalignReg;

    always_comb begin
        pcNext          = pcReg;
        outstandingNext = outstandingReg;
        dropNext        = dropReg;
        if (BranchTaken) begin
            pcNext          = {BranchTarget[dataW-1:2], 2'b00};
            outstandingNext = '0;
            // Every in-flight fetch becomes stale; a response landing this
            // cycle retires one of them (stale or live) right now.
            dropNext        = dropReg + DropW'(outstandingReg) - DropW'(MemRespValid);
        end else begin
            if (reqAccept) pcNext = pcReg + dataW'(4);
            if (MemRespValid && dropping) dropNext = dropReg - DropW'(1);
            outstandingNext = outstandingReg + CntW'(reqAccept) - CntW'(respKeep);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg          <= ResetVector;
            outstandingReg <= '0;
            dropReg        <= '0;
            misalignReg    <= 1'b0;
        end else begin
            pcReg          <= pcNext;
            outstandingReg <= outstandingNext;
            dropReg        <= dropNext;
            misalignReg    <= BranchTaken && (BranchTarget[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_instr_fetch_r32i.sv
// Directed testbench for instr_fetch_r32i. A behavioural memory returns
// addr ^ 32'hDEAD_BEEF after a programmable latency; a monitor logs every
// request accept and decoder pop, and each test task checks those logs and the
// DUT outputs against hand-derived expectations.
module tb_instr_fetch_r32i;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemReqValid;
    logic        MemReqReady = 1'b1;
    logic [31:0] MemReqAddr;
    logic        MemRespValid = 1'b0;
    logic [31:0] MemRespData = '0;
    logic        InsValid;
    logic        InsReady = 1'b1;
    logic [31:0] rawIns;
    logic [31:0] InsAddr;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        MisalignErr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int memLat = 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } respT;

    respT        respQ[$];
    logic [31:0] reqLog[$];
    logic [31:0] popAddr[$];
    logic [31:0] popData[$];
    int          popCyc[$];

    instr_fetch_r32i dut (
        .clk          (clk),
        .reset        (reset),
        .MemReqValid  (MemReqValid),
        .MemReqReady  (MemReqReady),
        .MemReqAddr   (MemReqAddr),
        .MemRespValid (MemRespValid),
        .MemRespData  (MemRespData),
        .InsValid     (InsValid),
        .InsReady     (InsReady),
        .rawIns       (rawIns),
        .InsAddr      (InsAddr),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .MisalignErr  (MisalignErr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model and monitor: sample handshakes on the edge, then drive the
    // response for the new cycle 1 time unit later.
    always @(posedge clk) begin
        if (reset) begin
            respQ.delete();
        end else if (MemReqValid && MemReqReady) begin
            respQ.push_back('{due: cyc + memLat, data: memWord(MemReqAddr)});
            reqLog.push_back(MemReqAddr);
        end
        if (!reset && !BranchTaken && InsValid && InsReady) begin
            popAddr.push_back(InsAddr);
            popData.push_back(rawIns);
            popCyc.push_back(cyc);
        end
        #1;
        cyc = cyc + 1;
        if (respQ.size() > 0 && respQ[0].due == cyc) begin
            MemRespValid = 1'b1;
            MemRespData  = respQ[0].data;
            void'(respQ.pop_front());
        end else begin
            MemRespValid = 1'b0;
            MemRespData  = '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Two reset cycles, then release; returns #1 into the first live cycle.
    task automatic doReset(input int lat);
        reset = 1'b1;
        BranchTaken = 1'b0;
        InsReady = 1'b1;
        tick(2);
        memLat = lat;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        tick(2);
        checks++;
        if (MemReqValid !== 1'b0 || InsValid !== 1'b0 || rawIns !== Nop ||
            InsAddr !== 32'h0 || MisalignErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: reqV=%b insV=%b raw=%h addr=%h mis=%b, want 0 0 %h 0 0",
                     MemReqValid, InsValid, rawIns, InsAddr, MisalignErr, Nop);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: valid=%b addr=%h, want 1 00000000", MemReqValid, MemReqAddr);
        end
        $display("test_reset done");
    endtask

    task automatic test_stream;
        int rel = cyc;
        int iReq = reqLog.size();
        int iPop = popAddr.size();
        int n;
        tick(12);
        checks++;
        if (popAddr.size() - iPop < 8) begin
            errors++;
            $display("FAIL stream_count: got %0d pops, want at least 8", popAddr.size() - iPop);
        end
        n = (popAddr.size() - iPop < 8) ? popAddr.size() - iPop : 8;
        for (int j = 0; j < n; j++) begin
            checks++;
            if (reqLog[iReq+j] !== 32'(4*j) || popAddr[iPop+j] !== 32'(4*j) ||
                popData[iPop+j] !== memWord(32'(4*j)) || popCyc[iPop+j] != rel + 2 + j) begin
                errors++;
                $display("FAIL stream_%0d: req=%h addr=%h ins=%h cyc=%0d, want %h %h %h %0d", j,
                         reqLog[iReq+j], popAddr[iPop+j], popData[iPop+j], popCyc[iPop+j] - rel,
                         32'(4*j), 32'(4*j), memWord(32'(4*j)), 2 + j);
            end
            $display("stream pop %0d addr=%h ins=%h", j, popAddr[iPop+j], popData[iPop+j]);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] lastAddr = popAddr[popAddr.size()-1];
        logic [31:0] heldAddr, heldIns, expA;
        bit stable = 1'b1;
        int iPop, n;
        InsReady = 1'b0;
        #1;
        heldAddr = InsAddr;
        heldIns  = rawIns;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (InsValid !== 1'b1 || InsAddr !== heldAddr || rawIns !== heldIns) stable = 1'b0;
        end
        checks++;
        if (!stable || heldAddr !== lastAddr + 32'd4 || heldIns !== memWord(lastAddr + 32'd4)) begin
            errors++;
            $display("FAIL stall_hold: stable=%b addr=%h ins=%h, want 1 %h %h", stable,
                     heldAddr, heldIns, lastAddr + 32'd4, memWord(lastAddr + 32'd4));
        end
        checks++;
        if (MemReqValid !== 1'b0 || reqLog.size() - popAddr.size() != 4) begin
            errors++;
            $display("FAIL stall_credit: reqV=%b inflight=%0d, want 0 4", MemReqValid,
                     reqLog.size() - popAddr.size());
        end
        iPop = popAddr.size();
        InsReady = 1'b1;
        tick(10);
        checks++;
        if (popAddr.size() - iPop < 8) begin
            errors++;
            $display("FAIL release_count: got %0d pops, want at least 8", popAddr.size() - iPop);
        end
        n = (popAddr.size() - iPop < 8) ? popAddr.size() - iPop : 8;
        for (int j = 0; j < n; j++) begin
            expA = lastAddr + 32'(4*(j+1));
            checks++;
            if (popAddr[iPop+j] !== expA || popData[iPop+j] !== memWord(expA)) begin
                errors++;
                $display("FAIL release_%0d: addr=%h ins=%h, want %h %h", j,
                         popAddr[iPop+j], popData[iPop+j], expA, memWord(expA));
            end
        end
        $display("backpressure held %h, released %0d pops", heldAddr, n);
    endtask

    // Pops since index iPop must be 'want' consecutive words starting at base.
    task automatic checkSeq(input string name, input int iPop, input logic [31:0] base, input int want);
        int n;
        logic [31:0] expA;
        checks++;
        if (popAddr.size() - iPop < want) begin
            errors++;
            $display("FAIL %s_count: got %0d pops, want at least %0d", name, popAddr.size() - iPop, want);
        end
        n = (popAddr.size() - iPop < want) ? popAddr.size() - iPop : want;
        for (int j = 0; j < n; j++) begin
            expA = base + 32'(4*j);
            checks++;
            if (popAddr[iPop+j] !== expA || popData[iPop+j] !== memWord(expA)) begin
                errors++;
                $display("FAIL %s_%0d: addr=%h ins=%h, want %h %h", name, j,
                         popAddr[iPop+j], popData[iPop+j], expA, memWord(expA));
            end
        end
        $display("%s: %0d pops from %h", name, n, base);
    endtask

    task automatic test_redirect;
        int iPop;
        doReset(3);
        tick(3);
        iPop = popAddr.size();
        BranchTaken = 1'b1;
        BranchTarget = 32'h0000_0100;
        #1;
        checks++;
        if (MemReqValid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_noreq: reqV=%b, want 0", MemReqValid);
        end
        tick(1);
        BranchTaken = 1'b0;
        #1;
        checks++;
        if (InsValid !== 1'b0 || MemReqValid !== 1'b1 || MemReqAddr !== 32'h100 || MisalignErr !== 1'b0) begin
            errors++;
            $display("FAIL redirect_next: insV=%b reqV=%b addr=%h mis=%b, want 0 1 00000100 0",
                     InsValid, MemReqValid, MemReqAddr, MisalignErr);
        end
        tick(20);
        checkSeq("redirect", iPop, 32'h100, 6);
    endtask

    task automatic test_misalign;
        int iPop;
        doReset(1);
        tick(4);
        BranchTaken = 1'b1;
        BranchTarget = 32'h0000_0102;
        tick(1);
        iPop = popAddr.size();
        BranchTaken = 1'b0;
        #1;
        checks++;
        if (MisalignErr !== 1'b1 || MemReqAddr !== 32'h100) begin
            errors++;
            $display("FAIL misalign_pulse: mis=%b addr=%h, want 1 00000100", MisalignErr, MemReqAddr);
        end
        tick(1);
        checks++;
        if (MisalignErr !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear: mis=%b, want 0", MisalignErr);
        end
        tick(6);
        checkSeq("misalign", iPop, 32'h100, 3);
    endtask

    task automatic test_wrap;
        int iPop, iReq;
        logic [31:0] expReq [4];
        expReq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        doReset(1);
        tick(2);
        BranchTaken = 1'b1;
        BranchTarget = 32'hFFFF_FFF8;
        tick(1);
        BranchTaken = 1'b0;
        iPop = popAddr.size();
        iReq = reqLog.size();
        tick(8);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (reqLog.size() <= iReq + j || reqLog[iReq+j] !== expReq[j]) begin
                errors++;
                $display("FAIL wrap_req_%0d: want %h (log size %0d)", j, expReq[j], reqLog.size() - iReq);
            end
        end
        checkSeq("wrap", iPop, 32'hFFFF_FFF8, 4);
    endtask

    task automatic test_back_to_back;
        int iPop;
        doReset(3);
        tick(3);
        iPop = popAddr.size();
        BranchTaken = 1'b1;
        BranchTarget = 32'h0000_0200;
        tick(1);
        BranchTarget = 32'h0000_0300;
        tick(1);
        BranchTaken = 1'b0;
        tick(20);
        checkSeq("back_to_back", iPop, 32'h300, 5);
    endtask

    task automatic test_reset_midflight;
        int iPop;
        doReset(3);
        InsReady = 1'b0;
        tick(5);
        checks++;
        if (InsValid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_prefill: insV=%b, want 1", InsValid);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (MemReqValid !== 1'b0 || InsValid !== 1'b0 || rawIns !== Nop ||
            InsAddr !== 32'h0 || MisalignErr !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: reqV=%b insV=%b raw=%h addr=%h mis=%b, want 0 0 %h 0 0",
                     MemReqValid, InsValid, rawIns, InsAddr, MisalignErr, Nop);
        end
        reset = 1'b0;
        InsReady = 1'b1;
        #1;
        checks++;
        if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h0) begin
            errors++;
            $display("FAIL midflight_restart: reqV=%b addr=%h, want 1 00000000", MemReqValid, MemReqAddr);
        end
        iPop = popAddr.size();
        tick(16);
        checkSeq("midflight", iPop, 32'h0, 5);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
